// File: rtl/tread_lever_mapper.sv
`default_nettype none
// ============================================================================
// Module      : tread_lever_mapper
// Description : Converts N digital 8-way joysticks plus fire into two-lever
//               tank controls, one left and one right tread per player.
//               Each tread lever drives forward or back. Every input bit is
//               debounced. Several steering modes are available. A
//               diagonal-release hold suppresses spurious half-steps.
//               Autofire is per player, and output polarity is selectable.
// Ports       : clk_sys      - system clock, rising edge
//               Reset_n      - synchronous active-low reset
//               ce           - sample tick for the debounce, hold and
//                              autofire counters
//               mode         - 0/3 standard, 1 car-reverse, 2 raw levers
//               autofire_en  - per-player autofire enable
//               joy_in       - per player {up, down, left, right}, active high
//               fire_in      - per-player fire button, active high
//               tread_out    - per player {L_fw, L_bk, R_fw, R_bk}
//               fire_out     - per-player fire after debounce and autofire
// Revision    : 1.0 - initial release
// ============================================================================
module tread_lever_mapper #(
    parameter int NUM_PLAYERS   = 2,
    parameter int DEBOUNCE      = 4,
    parameter int DIAG_HOLD     = 3,
    parameter int AUTOFIRE_HALF = 6,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic                     clk_sys,
    input  logic                     Reset_n,
    input  logic                     ce,
    input  logic [1:0]               mode,
    input  logic [NUM_PLAYERS-1:0]   autofire_en,
    input  logic [4*NUM_PLAYERS-1:0] joy_in,
    input  logic [NUM_PLAYERS-1:0]   fire_in,
    output logic [4*NUM_PLAYERS-1:0] tread_out,
    output logic [NUM_PLAYERS-1:0]   fire_out
);

    localparam logic [7:0] c_db_limit  = 8'(DEBOUNCE);
    localparam logic [7:0] c_hold_init = 8'(DIAG_HOLD);
    localparam logic [7:0] c_af_half   = 8'(AUTOFIRE_HALF);
    localparam logic       c_pol       = (ACTIVE_LOW != 0);
    localparam logic [3:0] c_inactive  = {4{c_pol}};

    typedef enum logic [0:0] {
        ST_TRACK = 1'b0,
        ST_HOLD  = 1'b1
    } hold_state_t;

    // Direction codes are the cancelled {up, down, left, right} vector itself.
    // Only nine values can occur after cancellation.
    function automatic logic [3:0] lever_map(input logic [3:0] code, input logic [1:0] md);
        logic [3:0] lv;
        lv = 4'b0000;
        if (md == 2'd2) begin
            lv = code;
        end else begin
            case (code)
                4'b1000: lv = 4'b1010;                          // U
                4'b1010: lv = 4'b0010;                          // UL
                4'b1001: lv = 4'b1000;                          // UR
                4'b0001: lv = 4'b1001;                          // R
                4'b0010: lv = 4'b0110;                          // L
                4'b0100: lv = 4'b0101;                          // D
                4'b0101: lv = (md == 2'd1) ? 4'b0001 : 4'b0100; // DR
                4'b0110: lv = (md == 2'd1) ? 4'b0100 : 4'b0001; // DL
                default: lv = 4'b0000;                          // N
            endcase
        end
        return lv;
    endfunction

    function automatic logic is_cardinal(input logic [3:0] code);
        return (code == 4'b1000) || (code == 4'b0100) ||
               (code == 4'b0010) || (code == 4'b0001);
    endfunction

    // Mode is tracked so that any change can drop every player out of HOLD.
    logic [1:0] r_mode;
    logic       w_mode_chg;
    logic       w_hold_en;

    always_ff @(posedge clk_sys) begin
        if (!Reset_n) begin
            r_mode <= 2'd0;
        end else begin
            r_mode <= mode;
        end
    end

    assign w_mode_chg = (mode != r_mode);
    assign w_hold_en  = (DIAG_HOLD != 0) && (mode != 2'd2) && !w_mode_chg;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        // Bit order: [4] up, [3] down, [2] left, [1] right, [0] fire.
        logic [4:0]  w_raw;
        logic [4:0]  r_filt;
        logic [7:0]  r_db_cnt [5];
        logic [3:0]  w_dec;
        logic        w_diag_prev;
        logic        w_component;
        hold_state_t r_state, w_state_n;
        logic [7:0]  r_hold_cnt, w_hold_cnt_n;
        logic [3:0]  r_disp, w_disp_n;
        logic [3:0]  r_tread;
        logic        r_af_ph, w_af_ph_n;
        logic [7:0]  r_af_cnt, w_af_cnt_n;
        logic        r_fire;
        logic        w_fire_n;

        assign w_raw = {joy_in[4*p +: 4], fire_in[p]};

        // Each bit has its own debounce counter.
        always_ff @(posedge clk_sys) begin
            if (!Reset_n) begin
                r_filt <= 5'b0;
                for (int b = 0; b < 5; b++) begin
                    r_db_cnt[b] <= 8'd0;
                end
            end else if (ce) begin
                for (int b = 0; b < 5; b++) begin
                    if (w_raw[b] != r_filt[b]) begin
                        if (r_db_cnt[b] + 8'd1 >= c_db_limit) begin
                            r_filt[b]   <= w_raw[b];
                            r_db_cnt[b] <= 8'd0;
                        end else begin
                            r_db_cnt[b] <= r_db_cnt[b] + 8'd1;
                        end
                    end else begin
                        r_db_cnt[b] <= 8'd0;
                    end
                end
            end
        end

        // Opposite directions cancel each other.
        assign w_dec = {r_filt[4] & ~r_filt[3], r_filt[3] & ~r_filt[4],
                        r_filt[2] & ~r_filt[1], r_filt[1] & ~r_filt[2]};

        assign w_diag_prev = (r_disp[3] | r_disp[2]) & (r_disp[1] | r_disp[0]);
        // A component cardinal of the displayed diagonal sets no bit outside it.
        assign w_component = is_cardinal(w_dec) && ((w_dec & ~r_disp) == 4'b0000);

        // Diagonal hold. The default leaves HOLD and shows the decoded code.
        // That default covers N, the opposite cardinal, another diagonal and a
        // return to the held diagonal. It also lets a decoded change win over
        // an expiry on the same tick.
        always_comb begin
            w_state_n    = ST_TRACK;
            w_hold_cnt_n = 8'd0;
            w_disp_n     = w_dec;
            if (w_hold_en) begin
                if (r_state == ST_TRACK) begin
                    if (w_diag_prev && w_component) begin
                        w_state_n    = ST_HOLD;
                        w_hold_cnt_n = c_hold_init;
                        w_disp_n     = r_disp;
                    end
                end else if (w_component) begin
                    w_state_n    = ST_HOLD;
                    w_hold_cnt_n = r_hold_cnt;
                    w_disp_n     = r_disp;
                    if (ce) begin
                        if (r_hold_cnt <= 8'd1) begin
                            w_state_n    = ST_TRACK;
                            w_hold_cnt_n = 8'd0;
                            w_disp_n     = w_dec;
                        end else begin
                            w_hold_cnt_n = r_hold_cnt - 8'd1;
                        end
                    end
                end
            end
        end

        // Autofire phase. Released fire, or autofire disabled, parks the
        // phase at asserted, so every press or re-enable starts asserted.
        always_comb begin
            w_af_ph_n  = 1'b1;
            w_af_cnt_n = 8'd0;
            if (r_filt[0] && autofire_en[p]) begin
                w_af_ph_n  = r_af_ph;
                w_af_cnt_n = r_af_cnt;
                if (ce) begin
                    if (r_af_cnt + 8'd1 >= c_af_half) begin
                        w_af_cnt_n = 8'd0;
                        w_af_ph_n  = ~r_af_ph;
                    end else begin
                        w_af_cnt_n = r_af_cnt + 8'd1;
                    end
                end
            end
        end

        assign w_fire_n = r_filt[0] & (~autofire_en[p] | r_af_ph);

        always_ff @(posedge clk_sys) begin
            if (!Reset_n) begin
                r_state    <= ST_TRACK;
                r_hold_cnt <= 8'd0;
                r_disp     <= 4'b0000;
                r_tread    <= c_inactive;
                r_af_ph    <= 1'b1;
                r_af_cnt   <= 8'd0;
                r_fire     <= c_pol;
            end else begin
                r_state    <= w_state_n;
                r_hold_cnt <= w_hold_cnt_n;
                r_disp     <= w_disp_n;
                r_tread    <= lever_map(w_disp_n, mode) ^ c_inactive;
                r_af_ph    <= w_af_ph_n;
                r_af_cnt   <= w_af_cnt_n;
                r_fire     <= w_fire_n ^ c_pol;
            end
        end

        assign tread_out[4*p +: 4] = r_tread;
        assign fire_out[p]         = r_fire;
    end

endmodule
`default_nettype wire

// File: tb/tb_tread_lever_mapper.sv
`default_nettype none
// ============================================================================
// Module      : tb_tread_lever_mapper
// Description : Directed self-checking bench for tread_lever_mapper with
//               four players. It uses DEBOUNCE=4, DIAG_HOLD=3,
//               AUTOFIRE_HALF=2 and active-low outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tread_lever_mapper;

    localparam int NP = 4;

    logic          clk_sys = 1'b0;
    logic          Reset_n;
    logic          ce;
    logic [1:0]    mode;
    logic [NP-1:0] autofire_en;
    logic [4*NP-1:0] joy_in;
    logic [NP-1:0] fire_in;
    logic [4*NP-1:0] tread_out;
    logic [NP-1:0] fire_out;

    int checks   = 0;
    int failures = 0;

    tread_lever_mapper #(
        .NUM_PLAYERS  (NP),
        .DEBOUNCE     (4),
        .DIAG_HOLD    (3),
        .AUTOFIRE_HALF(2),
        .ACTIVE_LOW   (1)
    ) dut (
        .clk_sys    (clk_sys),
        .Reset_n    (Reset_n),
        .ce         (ce),
        .mode       (mode),
        .autofire_en(autofire_en),
        .joy_in     (joy_in),
        .fire_in    (fire_in),
        .tread_out  (tread_out),
        .fire_out   (fire_out)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic set_dir(input int p, input logic [3:0] d);
        joy_in[4*p +: 4] = d;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        joy_in  = 16'h9999;
        fire_in = 4'hF;
        repeat (3) tick();
        checks++;
        if (tread_out !== 16'hFFFF) begin
            failures++;
            $display("FAIL reset_tread got=%h exp=%h", tread_out, 16'hFFFF);
        end
        checks++;
        if (fire_out !== 4'hF) begin
            failures++;
            $display("FAIL reset_fire got=%h exp=%h", fire_out, 4'hF);
        end
        Reset_n = 1'b1;
        tick();
        checks++;
        if ({tread_out, fire_out} !== 20'hFFFFF) begin
            failures++;
            $display("FAIL post_reset got=%h exp=%h", {tread_out, fire_out}, 20'hFFFFF);
        end
        joy_in  = '0;
        fire_in = '0;
        repeat (6) tick();
    endtask

    task automatic test_debounce();
        ce = 1'b0;
        set_dir(0, 4'b1000);
        repeat (10) tick();
        checks++;
        if (tread_out[3:0] !== 4'b1111) begin
            failures++;
            $display("FAIL ce_gating got=%b exp=%b", tread_out[3:0], 4'b1111);
        end
        ce = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (tread_out[3:0] !== 4'b1111) begin
                failures++;
                $display("FAIL debounce_wait%0d got=%b exp=%b", i, tread_out[3:0], 4'b1111);
            end
        end
        tick();
        checks++;
        if (tread_out[3:0] !== 4'b0101) begin
            failures++;
            $display("FAIL debounce_accept got=%b exp=%b", tread_out[3:0], 4'b0101);
        end
        set_dir(0, 4'b0000);
        repeat (5) tick();
        checks++;
        if (tread_out[3:0] !== 4'b1111) begin
            failures++;
            $display("FAIL debounce_release got=%b exp=%b", tread_out[3:0], 4'b1111);
        end
        set_dir(0, 4'b1000);
        repeat (3) tick();
        set_dir(0, 4'b0000);
        repeat (5) tick();
        checks++;
        if (tread_out[3:0] !== 4'b1111) begin
            failures++;
            $display("FAIL debounce_glitch got=%b exp=%b", tread_out[3:0], 4'b1111);
        end
    endtask

    task automatic test_modes();
        mode = 2'd0;
        set_dir(0, 4'b0110);
        repeat (5) tick();
        checks++;
        if (tread_out[3:0] !== 4'b1110) begin
            failures++;
            $display("FAIL mode0_dl got=%b exp=%b", tread_out[3:0], 4'b1110);
        end
        mode = 2'd1;
        tick();
        checks++;
        if (tread_out[3:0] !== 4'b1011) begin
            failures++;
            $display("FAIL mode1_dl got=%b exp=%b", tread_out[3:0], 4'b1011);
        end
        mode = 2'd2;
        tick();
        checks++;
        if (tread_out[3:0] !== 4'b1001) begin
            failures++;
            $display("FAIL mode2_dl got=%b exp=%b", tread_out[3:0], 4'b1001);
        end
        set_dir(0, 4'b1010);
        repeat (5) tick();
        checks++;
        if (tread_out[3:0] !== 4'b0101) begin
            failures++;
            $display("FAIL mode2_ul got=%b exp=%b", tread_out[3:0], 4'b0101);
        end
        mode = 2'd0;
        set_dir(0, 4'b1101);
        repeat (5) tick();
        checks++;
        if (tread_out[3:0] !== 4'b0110) begin
            failures++;
            $display("FAIL cancel_udr got=%b exp=%b", tread_out[3:0], 4'b0110);
        end
    endtask

    task automatic test_diag_hold();
        set_dir(0, 4'b0000);
        repeat (5) tick();
        set_dir(0, 4'b1001);
        repeat (5) tick();
        checks++;
        if (tread_out[3:0] !== 4'b0111) begin
            failures++;
            $display("FAIL hold_ur got=%b exp=%b", tread_out[3:0], 4'b0111);
        end
        // Release to U: the decoded U arrives on tick 5, then is held for 3 ce.
        set_dir(0, 4'b1000);
        repeat (5) tick();
        checks++;
        if (tread_out[3:0] !== 4'b0111) begin
            failures++;
            $display("FAIL hold_enter got=%b exp=%b", tread_out[3:0], 4'b0111);
        end
        repeat (2) tick();
        checks++;
        if (tread_out[3:0] !== 4'b0111) begin
            failures++;
            $display("FAIL hold_mid got=%b exp=%b", tread_out[3:0], 4'b0111);
        end
        tick();
        checks++;
        if (tread_out[3:0] !== 4'b0101) begin
            failures++;
            $display("FAIL hold_expire got=%b exp=%b", tread_out[3:0], 4'b0101);
        end
        set_dir(0, 4'b1001);
        repeat (5) tick();
        set_dir(0, 4'b0010);
        repeat (4) tick();
        checks++;
        if (tread_out[3:0] !== 4'b0111) begin
            failures++;
            $display("FAIL hold_pre_l got=%b exp=%b", tread_out[3:0], 4'b0111);
        end
        tick();
        checks++;
        if (tread_out[3:0] !== 4'b1001) begin
            failures++;
            $display("FAIL hold_skip_l got=%b exp=%b", tread_out[3:0], 4'b1001);
        end
    endtask

    task automatic test_autofire();
        logic [8:0] exp0;
        exp0        = 9'b011001111;
        autofire_en = 4'b0001;
        fire_in     = 4'b0011;
        for (int k = 1; k <= 9; k++) begin
            tick();
            checks++;
            if (fire_out[0] !== exp0[k-1]) begin
                failures++;
                $display("FAIL autofire_k%0d got=%b exp=%b", k, fire_out[0], exp0[k-1]);
            end
            if (k >= 5) begin
                checks++;
                if (fire_out[1] !== 1'b0) begin
                    failures++;
                    $display("FAIL plain_fire_k%0d got=%b exp=%b", k, fire_out[1], 1'b0);
                end
            end
        end
        fire_in = 4'b0000;
        repeat (4) tick();
        checks++;
        if (fire_out[0] !== 1'b0) begin
            failures++;
            $display("FAIL autofire_pre_release got=%b exp=%b", fire_out[0], 1'b0);
        end
        tick();
        checks++;
        if (fire_out[1:0] !== 2'b11) begin
            failures++;
            $display("FAIL autofire_release got=%b exp=%b", fire_out[1:0], 2'b11);
        end
        autofire_en = 4'b0000;
    endtask

    task automatic test_independence();
        set_dir(0, 4'b1000);
        set_dir(1, 4'b0001);
        set_dir(2, 4'b0110);
        set_dir(3, 4'b1010);
        repeat (5) tick();
        checks++;
        if (tread_out !== 16'hDE65) begin
            failures++;
            $display("FAIL independence got=%h exp=%h", tread_out, 16'hDE65);
        end
    endtask

    task automatic test_reset_mid_hold();
        set_dir(1, 4'b0101);
        repeat (5) tick();
        checks++;
        if (tread_out[7:4] !== 4'b1011) begin
            failures++;
            $display("FAIL p1_dr got=%b exp=%b", tread_out[7:4], 4'b1011);
        end
        set_dir(1, 4'b0100);
        repeat (5) tick();
        checks++;
        if (tread_out[7:4] !== 4'b1011) begin
            failures++;
            $display("FAIL p1_hold got=%b exp=%b", tread_out[7:4], 4'b1011);
        end
        tick();
        Reset_n = 1'b0;
        tick();
        checks++;
        if ({tread_out, fire_out} !== 20'hFFFFF) begin
            failures++;
            $display("FAIL mid_reset got=%h exp=%h", {tread_out, fire_out}, 20'hFFFFF);
        end
        Reset_n = 1'b1;
        tick();
        checks++;
        if (tread_out !== 16'hFFFF) begin
            failures++;
            $display("FAIL mid_reset_release got=%h exp=%h", tread_out, 16'hFFFF);
        end
        repeat (4) tick();
        checks++;
        if (tread_out !== 16'hDEA5) begin
            failures++;
            $display("FAIL after_reset_dirs got=%h exp=%h", tread_out, 16'hDEA5);
        end
    endtask

    initial begin
        Reset_n     = 1'b0;
        ce          = 1'b1;
        mode        = 2'd0;
        autofire_en = '0;
        joy_in      = '0;
        fire_in     = '0;
        test_reset();
        test_debounce();
        test_modes();
        test_diag_hold();
        test_autofire();
        test_independence();
        test_reset_mid_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tread_lever_mapper.md
# tread_lever_mapper

Parametrised converter from N digital 8-way joysticks (plus fire) to two-lever tank controls: left/right tread, each forward/back, per player. It sits between the joystick merge logic (USB/DB9/DB15 select) and the game core's lever inputs. It generalises the fixed two-player 8-way-to-tread table with:

- per-bit debounce;
- selectable steering modes;
- a diagonal-release hold that suppresses spurious half-steps;
- per-player autofire;
- selectable output polarity.

## Interface

Parameters:
- NUM_PLAYERS, default 2: number of independent channels, 1..4.
- DEBOUNCE, default 4: consecutive differing `ce` samples required to accept an input change, 1..255.
- DIAG_HOLD, default 3: `ce` ticks a diagonal is held after release to an adjacent cardinal, 0..255; 0 disables the hold.
- AUTOFIRE_HALF, default 6: `ce` ticks per autofire phase, 1..255.
- ACTIVE_LOW, default 1: 1 = tread and fire outputs inverted (asserted = 0).

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- ce  in  1  sample tick for debounce, hold and autofire counters, typically once per video line.
- mode  in  2  steering mode, shared by all players: 0 standard, 1 car-reverse, 2 raw levers, 3 same as 0.
- autofire_en  in  NUM_PLAYERS  per-player autofire enable.
- joy_in  in  4*NUM_PLAYERS  per player p, bits [4p+3:4p] = {up, down, left, right}, active high, synchronous to clk_sys.
- fire_in  in  NUM_PLAYERS  fire buttons, active high.
- tread_out  out  4*NUM_PLAYERS  per player p, bits [4p+3:4p] = {L_fw, L_bk, R_fw, R_bk}, polarity per ACTIVE_LOW.
- fire_out  out  NUM_PLAYERS  fire after debounce and autofire, polarity per ACTIVE_LOW.

## Operation

- **Debounce.** Each of the 5 bits per player is debounced independently.
  - On `ce`: if raw ≠ filtered, the counter increments. When the counter reaches DEBOUNCE, filtered ← raw and counter ← 0.
  - On `ce` with raw = filtered, counter ← 0.
  - Counters are 8 bits and never wrap past DEBOUNCE.
- **Cancel.** After debounce, up&down both set → both treated as 0. Same rule for left&right.
- **Direction decode.** Result is one of 9 codes: N, U, UR, R, DR, D, DL, L, UL.
- **Mode 0 (standard) map**, giving {L_fw, L_bk, R_fw, R_bk}:
  - U = 1010
  - UL = 0010
  - UR = 1000
  - R = 1001
  - L = 0110
  - D = 0101
  - DR = 0100
  - DL = 0001
  - N = 0000
- **Mode 1 (car-reverse).** Same as mode 0 except DR = 0001 and DL = 0100.
- **Mode 2 (raw levers).** Outputs = {up, down, left, right} after cancel. The diagonal hold is bypassed.
- **Diagonal hold**, active when DIAG_HOLD > 0 and mode ≠ 2:
  - **States:** TRACK and HOLD, one state register per player.
  - **TRACK → HOLD:** when the displayed code is diagonal and the new decoded code is one of its two component cardinals. Hold counter ← DIAG_HOLD; the displayed code stays diagonal.
  - **HOLD:** decrements on `ce`.
    - Counter reaches 0 → TRACK, and the display shows the current decoded code.
    - Decoded code returns to the held diagonal → TRACK immediately.
    - Decoded code becomes anything else (N, opposite cardinal, another diagonal) → TRACK, and that code is displayed the same cycle.
  - **Mode change:** forces TRACK and clears the counter.
- **Autofire.**
  - autofire_en=0: fire_out = debounced fire.
  - autofire_en=1 while debounced fire is held: output asserted for AUTOFIRE_HALF `ce` ticks, deasserted for AUTOFIRE_HALF, repeating. The sequence always starts asserted at press.
  - Release deasserts the output immediately and resets the phase counter.
  - Toggling autofire_en mid-hold restarts the phase at asserted.

## Timing

- **Reset.** While Reset_n=0 at a clock edge:
  - all counters ← 0, filtered bits ← 0, state ← TRACK;
  - tread_out ← all inactive: all ones if ACTIVE_LOW=1, else zeros;
  - fire_out ← inactive.
  - Reset mid-hold or mid-debounce discards all progress.
- **Latency.**
  - Filtered bits update at the edge of the DEBOUNCE-th qualifying `ce`.
  - tread_out and fire_out are registered and update on the next clk_sys edge: 1 cycle after the filtered change.
  - mode and autofire_en changes take effect on tread_out/fire_out 1 cycle later.
- **`ce` gating.** With `ce` held low, nothing but mode/autofire_en changes propagates. Two consecutive `ce` cycles count as two samples.
- **Simultaneous events.** A hold expiry and a decoded change on the same `ce`: the decoded code wins. Players are fully independent.

## Test plan

- **Reset.** ACTIVE_LOW=1, drive inputs active during reset → tread_out = all ones and fire_out = all ones during reset and for 1 cycle after release.
- **Debounce.** DEBOUNCE=4, `ce` every cycle, P0 up asserted → tread_out[3:0] stays 1111 for 4 `ce`, then 0101 one cycle later. A 3-sample glitch produces no change.
- **Mode maps.** Mode 0 DL → 0001 (active-high bench 1110 inverted). Mode 1 DL → 0100 (1011 inverted). Mode 2 up+left → {1,0,1,0} raw (0101 inverted). Up+down+right → R mapping.
- **Diagonal hold.** DIAG_HOLD=3, UR then release to U → UR mapping for 3 `ce`, then U. UR then L → L mapping on the next cycle (no hold).
- **Autofire.** AUTOFIRE_HALF=2, hold fire with autofire_en=1 → fire_out asserted 2 `ce`, deasserted 2, repeating. Release mid-phase → inactive next cycle.
- **Independence and reset mid-operation.** NUM_PLAYERS=4, different directions per player → each nibble correct. Reset pulsed during a P1 hold → P1 returns to TRACK and outputs inactive.
